// File: rtl/seq_alu_if.sv
// Handshake and data bundle between a controller and the seq_alu block.
// The controller drives start/op/operands; the ALU returns result and status.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [SHW-1:0]   inC;
  logic [WIDTH-1:0] ans;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output start, op, inA, inB, inC,
    input  ans, busy, done, zero, carry, ovf
  );

  modport slave (
    input  start, op, inA, inB, inC,
    output ans, busy, done, zero, carry, ovf
  );
endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: add/sub/logic finish in one clock, shifts
// iterate one bit per clock; start/busy/done handshake with status flags.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] shift_one(input logic [2:0] sop,
                                                 input logic [WIDTH-1:0] v);
    case (sop)
      OP_SRA:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SRL:  shift_one = {1'b0, v[WIDTH-1:1]};
      default: shift_one = {v[WIDTH-2:0], 1'b0};
    endcase
  endfunction

  logic [0:0]       state_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] acc_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] ans_r;
  logic             zero_r;
  logic             carry_r;
  logic             ovf_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;
  logic             res_carry_s;
  logic             res_ovf_s;
  logic             is_shift_s;
  logic             accept_s;
  logic             long_shift_s;
  logic [WIDTH-1:0] step_s;

  // Single-cycle result and flags computed straight from the live operands
  always_comb begin
    sum_s       = {1'b0, bus.inA} + {1'b0, bus.inB};
    diff_s      = {1'b0, bus.inA} - {1'b0, bus.inB};
    res_s       = {WIDTH{1'b0}};
    res_carry_s = 1'b0;
    res_ovf_s   = 1'b0;
    is_shift_s  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_s       = sum_s[WIDTH-1:0];
        res_carry_s = sum_s[WIDTH];
        res_ovf_s   = (bus.inA[WIDTH-1] == bus.inB[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != bus.inA[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow
        res_s       = diff_s[WIDTH-1:0];
        res_carry_s = diff_s[WIDTH];
        res_ovf_s   = (bus.inA[WIDTH-1] != bus.inB[WIDTH-1]) &&
                      (diff_s[WIDTH-1] != bus.inA[WIDTH-1]);
      end
      OP_AND: res_s = bus.inA & bus.inB;
      OP_OR:  res_s = bus.inA | bus.inB;
      OP_XOR: res_s = bus.inA ^ bus.inB;
      OP_SRA, OP_SRL, OP_SLL: begin
        res_s      = bus.inA;
        is_shift_s = 1'b1;
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  assign accept_s     = bus.start && (state_r == IDLE);
  assign long_shift_s = is_shift_s && (bus.inC != {SHW{1'b0}});
  assign step_s       = shift_one(op_r, acc_r);

  // Control state, shift datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {SHW{1'b0}};
      ans_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && long_shift_s) begin
            op_r    <= bus.op;
            acc_r   <= bus.inA;
            cnt_r   <= bus.inC;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end else if (accept_s) begin
            ans_r   <= res_s;
            zero_r  <= (res_s == {WIDTH{1'b0}});
            carry_r <= res_carry_s;
            ovf_r   <= res_ovf_s;
            done_r  <= 1'b1;
          end
        end
        SHIFT: begin
          acc_r <= step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            ans_r   <= step_s;
            zero_r  <= (step_s == {WIDTH{1'b0}});
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ans   = ans_r;
  assign bus.zero  = zero_r;
  assign bus.carry = carry_r;
  assign bus.ovf   = ovf_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vector table, hand-written
// handshake/reset sequences, and random ops against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] c;
    logic [7:0] ans;
    logic       z;
    logic       cy;
    logic       v;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic and language shift operators
  task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] c, output logic [7:0] r, output logic z,
                       output logic cy, output logic v, output int lat);
    int ua, ub, sa, sb, full, sfull;
    logic signed [7:0] sv;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    cy = 1'b0; v = 1'b0; lat = 1; r = 8'h00;
    case (o)
      3'b011: begin
        full = ua + ub; r = 8'(full); cy = (full > 255);
        sfull = sa + sb; v = (sfull > 127) || (sfull < -128);
      end
      3'b010: begin
        full = ua - ub; r = 8'(full); cy = (ua < ub);
        sfull = sa - sb; v = (sfull > 127) || (sfull < -128);
      end
      3'b000: begin sv = a; r = sv >>> c; lat = (c == 3'd0) ? 1 : int'(c) + 1; end
      3'b001: begin r = a >> c; lat = (c == 3'd0) ? 1 : int'(c) + 1; end
      3'b100: begin r = a << c; lat = (c == 3'd0) ? 1 : int'(c) + 1; end
      3'b101: r = a & b;
      3'b110: r = a | b;
      default: r = a ^ b;
    endcase
    z = (r == 8'h00);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] c, input logic [7:0] e_ans,
                        input logic e_z, input logic e_c, input logic e_v, input int lat);
    bus.start = 1'b1; bus.op = o; bus.inA = a; bus.inB = b; bus.inC = c;
    step();
    // Scramble operands after acceptance; the DUT must use its latched copies
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.inA = 8'($urandom); bus.inB = 8'($urandom);
    bus.inC = 3'($urandom);
    for (int n = 1; n <= lat; n++) begin
      if (n < lat) begin
        chk1({nm, " busy"}, bus.busy, 1'b1);
        chk1({nm, " early done"}, bus.done, 1'b0);
        step();
      end else begin
        chk1({nm, " done"}, bus.done, 1'b1);
        chk1({nm, " busy at done"}, bus.busy, 1'b0);
        chk8({nm, " ans"}, bus.ans, e_ans);
        chk1({nm, " zero"}, bus.zero, e_z);
        chk1({nm, " carry"}, bus.carry, e_c);
        chk1({nm, " ovf"}, bus.ovf, e_v);
      end
    end
    step();
    chk1({nm, " done pulse width"}, bus.done, 1'b0);
    chk8({nm, " ans hold"}, bus.ans, e_ans);
  endtask

  initial begin
    logic [7:0] r, pa, pb;
    logic z, cy, v;
    int lat, ndone, dcyc;

    vecs[0]  = '{3'b011, 8'h7F, 8'h01, 3'd5, 8'h80, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{3'b011, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'b010, 8'h04, 8'h04, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'b010, 8'h03, 8'h05, 3'd0, 8'hFE, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{3'b010, 8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{3'b000, 8'hF0, 8'h55, 3'd3, 8'hFE, 1'b0, 1'b0, 1'b0, 4};
    vecs[6]  = '{3'b001, 8'hF0, 8'h55, 3'd3, 8'h1E, 1'b0, 1'b0, 1'b0, 4};
    vecs[7]  = '{3'b100, 8'h81, 8'hAA, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{3'b101, 8'hF0, 8'h3C, 3'd3, 8'h30, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b110, 8'hF0, 8'h3C, 3'd6, 8'hFC, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'b111, 8'hF0, 8'h3C, 3'd1, 8'hCC, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{3'b000, 8'h9A, 8'h11, 3'd0, 8'h9A, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{3'b100, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0, 1'b0, 8};
    vecs[13] = '{3'b000, 8'h80, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 8};
    vecs[14] = '{3'b001, 8'h01, 8'h00, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 2};

    // Reset held with a start request present: reset must win
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 3'b011; bus.inA = 8'h01; bus.inB = 8'h01; bus.inC = 3'd0;
    step();
    step();
    chk1("reset done", bus.done, 1'b0);
    chk1("reset busy", bus.busy, 1'b0);
    chk8("reset ans", bus.ans, 8'h00);
    chk1("reset zero", bus.zero, 1'b0);
    chk1("reset carry", bus.carry, 1'b0);
    chk1("reset ovf", bus.ovf, 1'b0);
    reset = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("idle no done", bus.done, 1'b0);
    end

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].ans, vecs[i].z, vecs[i].cy, vecs[i].v, vecs[i].lat);

    // SRL by 7 with an ADD request during busy, then an ADD in the done cycle
    bus.start = 1'b1; bus.op = 3'b001; bus.inA = 8'h80; bus.inB = 8'h00; bus.inC = 3'd7;
    step();
    bus.start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      chk1($sformatf("srl7 busy c%0d", cyc), bus.busy, logic'(cyc <= 7));
      if (bus.done) begin ndone++; dcyc = cyc; end
      if (cyc == 8) chk8("srl7 ans", bus.ans, 8'h01);
      if (cyc == 2) begin
        bus.start = 1'b1; bus.op = 3'b011; bus.inA = 8'h01; bus.inB = 8'h01; bus.inC = 3'd0;
      end else if (cyc == 8) begin
        bus.start = 1'b1; bus.op = 3'b011; bus.inA = 8'h05; bus.inB = 8'h06; bus.inC = 3'd0;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk8("srl7 done count", 8'(ndone), 8'd1);
    chk8("srl7 done cycle", 8'(dcyc), 8'd8);
    chk1("b2b add done", bus.done, 1'b1);
    chk8("b2b add ans", bus.ans, 8'h0B);
    step();
    chk1("b2b add pulse", bus.done, 1'b0);

    // Reset mid-shift aborts the operation with nonzero prior state
    run_op("pre-reset add", 3'b011, 8'hC0, 8'h80, 3'd0, 8'h40, 1'b0, 1'b1, 1'b1, 1);
    bus.start = 1'b1; bus.op = 3'b000; bus.inA = 8'hF0; bus.inC = 3'd5;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk8("abort ans", bus.ans, 8'h00);
    chk1("abort busy", bus.busy, 1'b0);
    chk1("abort done", bus.done, 1'b0);
    chk1("abort zero", bus.zero, 1'b0);
    chk1("abort carry", bus.carry, 1'b0);
    chk1("abort ovf", bus.ovf, 1'b0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) ndone++;
    end
    chk8("abort no late done", 8'(ndone), 8'd0);

    // Four ADDs with start held: one result per clock
    for (int i = 0; i < 4; i++) begin
      pa = 8'($urandom); pb = 8'($urandom);
      bus.start = 1'b1; bus.op = 3'b011; bus.inA = pa; bus.inB = pb;
      step();
      chk1($sformatf("stream done %0d", i), bus.done, 1'b1);
      chk8($sformatf("stream ans %0d", i), bus.ans, 8'(int'(pa) + int'(pb)));
    end
    bus.start = 1'b0;
    step();
    chk1("stream end", bus.done, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0] o, c;
      logic [7:0] a, b;
      o = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      c = 3'($urandom);
      model(o, a, b, c, r, z, cy, v, lat);
      run_op($sformatf("rnd%0d op%0d a%h b%h c%0d", i, o, a, b, c), o, a, b, c,
             r, z, cy, v, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered multi-cycle ALU. It generalises the 4-bit combinational add/sub/shift unit to WIDTH bits and eight operations, and adds status flags. Add, sub and logic ops complete in one cycle. Shifts run iteratively, one bit position per clock, so no barrel shifter is needed. A start/busy/done handshake lets a controller (e.g. a multi-cycle CPU datapath FSM) issue operations and wait for results.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request; sampled only when busy=0.
- op, input, 3, operation: 000 SRA, 001 SRL, 010 SUB, 011 ADD, 100 SLL, 101 AND, 110 OR, 111 XOR.
- inA, input, WIDTH, operand A / value to shift.
- inB, input, WIDTH, operand B; ignored for shifts.
- inC, input, SHW, shift amount 0..WIDTH-1; ignored for non-shifts.
- ans, output, WIDTH, registered result; held until the next completion.
- busy, output, 1, high while an iterative shift is in progress.
- done, output, 1, one-cycle pulse when ans/flags update.
- zero, output, 1, ans == 0, updated with ans.
- carry, output, 1, ADD carry-out or SUB borrow (inA < inB unsigned); 0 for other ops.
- ovf, output, 1, signed overflow for ADD/SUB; 0 for other ops.

Behaviour:
- Reset (sync, active-high): ans=0, zero=0, carry=0, ovf=0, done=0, busy=0, state=IDLE, internal accumulator and counter cleared. Reset wins over start on the same edge.
- States: IDLE, SHIFT. done is a registered pulse, not a separate state.
- Acceptance: at the end of cycle t, if busy=0 and start=1, the block latches op, operands and inC.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, and any shift with inC=0):
  - ans and flags are written at the acceptance edge; done=1 in cycle t+1.
  - The state stays IDLE.
  - A shift with inC=0 yields ans=inA.
- Shift with inC=k>0:
  - The acceptance edge loads acc=inA, cnt=k and moves the state to SHIFT; busy=1 from cycle t+1 through t+k.
  - Each edge in SHIFT shifts acc by one bit and decrements cnt. SRA fills with acc MSB, SRL fills 0 from the left, SLL fills 0 from the right.
  - On the edge where cnt==1, ans is written with the final shifted value, done=1, state returns to IDLE.
  - Result: done in cycle t+k+1, where busy=0.
- Arithmetic is modulo 2^WIDTH.
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: ans = inA - inB; carry = borrow.
  - ovf follows the standard sign rule: ADD when operand signs match and the result sign differs; SUB when operand signs differ and the result sign differs from inA.
- Flags zero, carry and ovf update only on completion, together with ans. Between completions, ans and flags hold.
- done is high for exactly one cycle per accepted operation, and never without a prior acceptance.
- start while busy=1 is ignored, not queued; the operation in progress is unaffected.
- start during the done cycle (busy=0) is accepted, so back-to-back ops are possible. Single-cycle ops sustain one result per clock with done high continuously.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Reset mid-shift aborts the operation: no done pulse, all outputs 0 next cycle.

Test Plan:
- WIDTH=8, ADD inA=8'h7F inB=8'h01 -> cycle t+1: ans=8'h80, ovf=1, carry=0, zero=0, done=1 for one cycle; ADD 8'hFF+8'h01 -> ans=8'h00, carry=1, zero=1, ovf=0.
- SUB 8'h04-8'h04 -> ans=8'h00, zero=1, carry=0; SUB 8'h03-8'h05 -> ans=8'hFE, carry=1, ovf=0; SUB 8'h80-8'h01 -> ans=8'h7F, ovf=1.
- SRA inA=8'hF0 inC=3 -> busy high 3 cycles, done at t+4, ans=8'hFE; SRL same operands -> ans=8'h1E; SLL 8'h81 by 1 -> ans=8'h02 at t+2. AND/OR/XOR of 8'hF0,8'h3C -> 8'h30/8'hFC/8'hCC at t+1.
- SRL inC=7 accepted, start pulsed with ADD during busy -> ADD ignored, single done with ans=8'h01 for inA=8'h80; ADD issued in the done cycle -> accepted, done one cycle later.
- Reset asserted at cycle t+2 of SRA by 5 -> next cycle ans=0, busy=0, done=0, flags 0; no later done pulse.
- SRA inA=8'h9A inC=0 -> done at t+1, ans=8'h9A, busy never asserted; 4 consecutive ADDs with start held -> done high 4 consecutive cycles with the matching sums.
